// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, receiver state encoding and baud divider arithmetic.
package uart_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;
  localparam int DATA_BITS = 8;
  localparam int SYNC_STAGES = 2;
  function automatic int uart_div(input int clk_freq, input int uart_freq);
    return clk_freq / uart_freq;
  endfunction
endpackage

// File: rtl/ip_uart_rx.sv
// ip_uart_rx: 8N1 UART receiver with held valid/ack handshake, framing-error pulse and sticky overrun.
module ip_uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq = 27000000,
  parameter int uart_freq = 115200
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       uart_rx,
  output logic [7:0] recv_data,
  output logic       recv_valid,
  input  logic       recv_ack,
  output logic       framing_error,
  output logic       overrun
);
  localparam int DIV = uart_div(clk_freq, uart_freq);
  localparam int HALF = DIV / 2;
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(DATA_BITS);
  if (DIV < 4) begin : g_div_chk
    $error("ip_uart_rx: clk_freq / uart_freq must be at least 4");
  end
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, fe_q, fe_d, ovr_q, ovr_d;
  logic rx_s, tick, stop_smp, deliver, acc;
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign tick = cnt_q == '0;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q  <= '1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx_s) state_d = ST_START;
      ST_START: if (tick) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && bit_q == BW'(DATA_BITS - 1)) state_d = ST_STOP;
      ST_STOP:  if (tick) state_d = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end
  // the counter free-runs outside IDLE; only the START/DATA/STOP sample points consume it
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], uart_rx};
    cnt_d    = state_q == ST_IDLE ? (rx_s ? cnt_q : CW'(HALF - 1))
             : tick ? CW'(DIV - 1) : cnt_q - CW'(1);
    bit_d    = state_q == ST_START ? '0 : (state_q == ST_DATA && tick) ? bit_q + BW'(1) : bit_q;
    shift_d  = (state_q == ST_DATA && tick) ? {rx_s, shift_q[DATA_BITS-1:1]} : shift_q;
    stop_smp = state_q == ST_STOP && tick;
    deliver  = stop_smp && rx_s;
    acc      = valid_q && recv_ack;
    data_d   = deliver ? shift_q : data_q;
    valid_d  = deliver || (valid_q && !recv_ack);
    fe_d     = stop_smp && !rx_s;
    ovr_d    = (deliver && valid_q && !recv_ack) ? 1'b1 : acc ? 1'b0 : ovr_q;
  end
  assign recv_data = data_q;
  assign recv_valid = valid_q;
  assign framing_error = fe_q;
  assign overrun = ovr_q;
endmodule
